// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared constants and FSM state type for the frame transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        SIZE  = 3'd3,
        DATA  = 3'd4,
        CRC   = 3'd5,
        STOP  = 3'd6
    } state_t;

    localparam logic [7:0] CRC_POLY   = 8'h07;
    localparam int         STUFF_RUN  = 5;
    localparam int         MAX_BYTES  = 15;
    localparam logic       START_BIT  = 1'b1;
    localparam logic       STOP_BIT   = 1'b0;
    localparam logic       IDLE_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/frame_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_transmitter_if
//  Description : Host-side byte source and serial line signals of the
//                frame transmitter. master = host, slave = transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_transmitter_if;
    logic [7:0] baudrate;
    logic       start;
    logic [3:0] fsize;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       TX;
    logic       busy;
    logic       done;

    modport master (
        output baudrate, start, fsize, din, din_valid,
        input  din_ready, TX, busy, done
    );

    modport slave (
        input  baudrate, start, fsize, din, din_valid,
        output din_ready, TX, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/frame_transmitter_crc8.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial
//  Description : Bit-serial CRC-8 (init 0x00, MSB-first, no reflection,
//                no final XOR); one message bit is absorbed per enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
    import frame_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       clear,
    input  wire logic       en,
    input  wire logic       bit_in,
    output logic [7:0]      crc
);

    logic [7:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[7] ^ bit_in;

    // Shift register LFSR: clear at frame acceptance, step on each payload bit
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_crc <= 8'h00;
        end else if (en) begin
            r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_transmitter
//  Description : Buffers 1-15 bytes and sends start, size, data, CRC-8 and
//                stop bits with bit stuffing, each bit held for B clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_transmitter
    import frame_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           reset,
    frame_transmitter_if.slave  bus
);

    state_t     r_state;
    logic       r_tx;
    logic       r_busy;
    logic       r_din_ready;
    logic       r_done;
    logic [7:0] r_baud;
    logic [7:0] r_baud_cnt;
    logic [3:0] r_fsize;
    logic [3:0] r_byte_idx;
    logic [2:0] r_bit_idx;
    logic [2:0] r_run;
    logic [7:0] r_buf [MAX_BYTES];

    logic       w_accept;
    logic       w_load;
    logic       w_last_load;
    logic       w_bit_end;
    logic       w_in_frame;
    logic       w_do_stuff;
    logic       w_crc_en;
    logic [7:0] w_crc;
    logic [2:0] w_bit_dec;
    logic [3:0] w_byte_inc;
    state_t     w_nxt_state;
    logic [2:0] w_nxt_bit_idx;
    logic [3:0] w_nxt_byte_idx;
    logic       w_nxt_val;
    logic       w_nxt_feed;

    assign w_accept    = (r_state == IDLE) && bus.start && (bus.fsize != 4'd0);
    assign w_load      = (r_state == LOAD) && bus.din_valid && r_din_ready;
    assign w_last_load = w_load && (r_byte_idx == r_fsize - 4'd1);
    assign w_bit_end   = (r_baud_cnt == r_baud - 8'd1);
    assign w_in_frame  = (r_state == START) || (r_state == SIZE) ||
                         (r_state == DATA)  || (r_state == CRC);
    assign w_do_stuff  = w_in_frame && (r_run == 3'(STUFF_RUN));
    assign w_bit_dec   = r_bit_idx - 3'd1;
    assign w_byte_inc  = r_byte_idx + 4'd1;
    assign w_crc_en    = w_in_frame && w_bit_end && !w_do_stuff && w_nxt_feed;

    // Next logical (unstuffed) line bit following the one currently sent
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_bit_idx  = r_bit_idx;
        w_nxt_byte_idx = r_byte_idx;
        w_nxt_val      = STOP_BIT;
        case (r_state)
            START: begin
                w_nxt_state   = SIZE;
                w_nxt_bit_idx = 3'd3;
                w_nxt_val     = r_fsize[3];
            end
            SIZE: begin
                if (r_bit_idx == 3'd0) begin
                    w_nxt_state    = DATA;
                    w_nxt_bit_idx  = 3'd7;
                    w_nxt_byte_idx = 4'd0;
                    w_nxt_val      = r_buf[0][7];
                end else begin
                    w_nxt_bit_idx = w_bit_dec;
                    w_nxt_val     = r_fsize[w_bit_dec[1:0]];
                end
            end
            DATA: begin
                if (r_bit_idx != 3'd0) begin
                    w_nxt_bit_idx = w_bit_dec;
                    w_nxt_val     = r_buf[r_byte_idx][w_bit_dec];
                end else if (r_byte_idx == r_fsize - 4'd1) begin
                    w_nxt_state   = CRC;
                    w_nxt_bit_idx = 3'd7;
                    w_nxt_val     = w_crc[7];
                end else begin
                    w_nxt_bit_idx  = 3'd7;
                    w_nxt_byte_idx = w_byte_inc;
                    w_nxt_val      = r_buf[w_byte_inc][7];
                end
            end
            CRC: begin
                if (r_bit_idx == 3'd0) begin
                    w_nxt_state = STOP;
                    w_nxt_val   = STOP_BIT;
                end else begin
                    w_nxt_bit_idx = w_bit_dec;
                    w_nxt_val     = w_crc[w_bit_dec];
                end
            end
            default: begin
                w_nxt_state = r_state;
            end
        endcase
        w_nxt_feed = (w_nxt_state == SIZE) || (w_nxt_state == DATA);
    end

    crc8_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept),
        .en     (w_crc_en),
        .bit_in (w_nxt_val),
        .crc    (w_crc)
    );

    // Payload buffer: contents need no reset, written only while loading
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_buf[r_byte_idx] <= bus.din;
        end
    end

    // Frame FSM with baud timing, stuffing and registered line outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tx        <= IDLE_LEVEL;
            r_busy      <= 1'b0;
            r_din_ready <= 1'b0;
            r_done      <= 1'b0;
            r_baud      <= 8'd1;
            r_baud_cnt  <= 8'd0;
            r_fsize     <= 4'd0;
            r_byte_idx  <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_run       <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= LOAD;
                        r_busy      <= 1'b1;
                        r_din_ready <= 1'b1;
                        r_fsize     <= bus.fsize;
                        r_baud      <= (bus.baudrate == 8'd0) ? 8'd1 : bus.baudrate;
                        r_byte_idx  <= 4'd0;
                    end
                end
                LOAD: begin
                    if (w_last_load) begin
                        r_state     <= START;
                        r_din_ready <= 1'b0;
                        r_tx        <= START_BIT;
                        r_run       <= 3'd1;
                        r_baud_cnt  <= 8'd0;
                    end else if (w_load) begin
                        r_byte_idx <= w_byte_inc;
                    end
                end
                START, SIZE, DATA, CRC: begin
                    if (!w_bit_end) begin
                        r_baud_cnt <= r_baud_cnt + 8'd1;
                    end else begin
                        r_baud_cnt <= 8'd0;
                        if (w_do_stuff) begin
                            // Stuff slot keeps the current state and indices
                            r_tx  <= ~r_tx;
                            r_run <= 3'd1;
                        end else begin
                            r_state    <= w_nxt_state;
                            r_bit_idx  <= w_nxt_bit_idx;
                            r_byte_idx <= w_nxt_byte_idx;
                            r_tx       <= w_nxt_val;
                            r_run      <= (w_nxt_val == r_tx) ? r_run + 3'd1 : 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (!w_bit_end) begin
                        r_baud_cnt <= r_baud_cnt + 8'd1;
                    end else begin
                        r_baud_cnt <= 8'd0;
                        r_state    <= IDLE;
                        r_tx       <= IDLE_LEVEL;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX        = r_tx;
    assign bus.busy      = r_busy;
    assign bus.din_ready = r_din_ready;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: doc/frame_transmitter.md
# frame_transmitter

Serial frame transmitter producing the line format consumed by the project's `receiver` block. It buffers 1-15 payload bytes and serializes them into a frame, holding each line bit for `baudrate` clocks. The frame is: start bit, 4-bit size, data, CRC-8, stop bit, with bit stuffing. It sits between the host-side byte source and the `TX` pin.

## Interface
Parameters:
- none. Constants live in `frame_pkg`.

Ports:
- `clk`  in  1  single system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baudrate`  in  8  clocks per line bit, latched when a frame is accepted; 0 is treated as 1.
- `start`  in  1  request to send a frame; sampled only in IDLE.
- `fsize`  in  4  payload byte count N, latched with `start`; 0 means the request is ignored.
- `din`  in  8  payload byte.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  the block accepts a byte this cycle.
- `TX`  out  1  serial line; idle level is 0.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- Line bit order:
  - start bit = 1;
  - `fsize` as 4 bits, MSB first;
  - N bytes in load order, each MSB first;
  - CRC-8, MSB first;
  - stop bit = 0.
- CRC-8:
  - polynomial 0x07, init 0x00, no reflection, no final XOR;
  - covers the 4 size bits plus the 8N data bits, unstuffed;
  - CRC bits and stuff bits are never fed back into the CRC.
- Bit stuffing:
  - A run counter tracks consecutive identical transmitted bits, beginning with the start bit.
  - Once 5 identical bits have been sent, the next line slot carries their complement as a stuff bit.
  - A stuff bit restarts the run at length 1.
  - Stuffing applies through the last CRC bit. A stuff bit may therefore sit between the CRC and the stop bit.
  - The stop bit is never stuffed and never counted.
- FSM states: IDLE, LOAD, START, SIZE, DATA, CRC, STOP.
  - IDLE -> LOAD when `start` is high and `fsize` is nonzero.
  - LOAD: `din_ready` is high. A byte is written into the 15x8 buffer on each cycle with `din_valid && din_ready`. After the Nth byte, go to START.
  - START -> SIZE -> DATA -> CRC -> STOP. Each state advances after its last bit period; stuff slots extend the current state.
  - STOP -> IDLE with `done` pulsed.
- `start` is ignored while `busy`. `din_valid` is ignored outside LOAD.
- Reset values: `TX`=0, `busy`=0, `din_ready`=0, `done`=0, state=IDLE, run counter=0, CRC=0x00. Buffer contents are don't-care.
- Reset mid-frame: `TX`=0 on the next cycle and the frame is abandoned. No `done` pulse.

## Timing
- Acceptance at cycle t: `busy` and `din_ready` go high at t+1.
- The Nth byte accepted at cycle u: `din_ready` goes low at u+1 and `TX` goes 1 (start bit) at u+1.
- Each line bit, data or stuff, lasts exactly B cycles, where B = max(`baudrate`, 1).
- The baud counter counts 0..B-1, and the bit changes on the cycle after count B-1.
- Frame length is B*(1+4+8N+8+1+S) cycles, where S is the stuff-bit count.
- The final stop-bit cycle is followed by `done`=1 and `busy`=0 on the same cycle. The state is IDLE that cycle, and a new `start` is accepted on it.
- `baudrate` changes after acceptance have no effect on the frame in flight.

## Structure
- `frame_pkg` holds:
  - the state enum;
  - CRC_POLY=8'h07;
  - STUFF_RUN=5;
  - MAX_BYTES=15;
  - START_BIT=1'b1, STOP_BIT=1'b0, IDLE_LEVEL=1'b0.
- Sub-module `crc8_serial` has ports (clk, reset, clear, en, bit_in, crc[7:0]). It does a one-bit-per-enable shift.
- Serializer, stuffing and baud counter are inline in `frame_transmitter`.

## Test plan
- Basic frame: N=1, `din`=0x00, B=2.
  - Required `TX` bit sequence: 1 0001 00000 [1] 000 00 [1] 010101 0. This is 24 bits, 48 cycles.
  - CRC is 0x15; the two [1] bits are stuffing.
  - `done` pulses on cycle 49 after the start bit begins.
- Start-run stuffing: N=15 with all bytes 0xFF, B=1.
  - A stuff 0 follows size bits 1111, because start plus four ones is five ones.
  - Every 5 data ones are followed by a 0.
  - CRC matches the model.
- Handshake: N=3 with `din_valid` deasserted on alternate cycles.
  - Exactly 3 bytes are accepted.
  - `din_ready` drops the cycle after the third byte.
  - `TX` starts that same cycle.
- Ignored requests:
  - `fsize`=0 with `start`=1 leaves `busy` at 0.
  - `start` pulses mid-frame leave the frame unchanged.
  - `baudrate`=0 gives 1-cycle bits.
- Reset mid-DATA: with `reset` high for 1 cycle, `TX`=0, `busy`=0 and `din_ready`=0 next cycle, and no `done`. A following frame is correct.
- Back-to-back: `start` asserted on the `done` cycle is accepted, and the second frame's CRC starts from 0x00.
